// File: rtl/exp7_sequenciador_pkg.sv
// Shared definitions for the memory-game round sequencer:
// state codes, round limits and default phase timings.
package exp7_pkg;

   localparam int TIMER_W = 13;

   localparam int T_MOSTRA_DEF = 1000;
   localparam int T_APAGA_DEF  = 250;
   localparam int T_LONGO_DEF  = 5000;
   localparam int T_CURTO_DEF  = 2000;

   localparam logic [3:0] ULTIMA_CURTO = 4'd7;
   localparam logic [3:0] ULTIMA_LONGO = 4'd15;

   // Encodings double as the db_estado debug code.
   typedef enum logic [3:0] {
      ST_INICIAL        = 4'h0,
      ST_PREPARACAO     = 4'h1,
      ST_MOSTRA         = 4'h2,
      ST_APAGA          = 4'h3,
      ST_ESPERA         = 4'h4,
      ST_REGISTRA       = 4'h5,
      ST_COMPARA        = 4'h6,
      ST_PROXIMA_JOGADA = 4'h7,
      ST_PROXIMA_RODADA = 4'h8,
      ST_FIM_ACERTOU    = 4'hA,
      ST_FIM_TIMEOUT    = 4'hD,
      ST_FIM_ERROU      = 4'hE
   } estado_t;

endpackage

// File: rtl/exp7_sequenciador_if.sv
// Link between the sequencer and the game datapath: memory address,
// LED source select and jogada register controls out; move flags back.
interface exp7_sequenciador_if;

   logic [3:0] endereco;
   logic       mostra_leds;
   logic       zeraR;
   logic       registraR;
   logic       jogada_feita;
   logic       jogada_correta;

   modport master (
      output endereco,
      output mostra_leds,
      output zeraR,
      output registraR,
      input  jogada_feita,
      input  jogada_correta
   );

   modport slave (
      input  endereco,
      input  mostra_leds,
      input  zeraR,
      input  registraR,
      output jogada_feita,
      output jogada_correta
   );

endinterface

// File: rtl/exp7_sequenciador_contador_m.sv
// Phase timer: counts while conta is high and flags the last cycle of the
// currently selected limit, then wraps back to zero.
module contador_m #(
   parameter int WIDTH = 13
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             zera,
   input  logic             conta,
   input  logic [WIDTH-1:0] limite,
   output logic             fim
);

   logic [WIDTH-1:0] valor;

   assign fim = conta && (valor == (limite - WIDTH'(1)));

   always_ff @(posedge clock) begin
      if (reset || zera) begin
         valor <= '0;
      end else if (conta) begin
         valor <= fim ? '0 : valor + WIDTH'(1);
      end
   end

endmodule

// File: rtl/exp7_sequenciador.sv
// Round sequencer for the memory game: replays the stored sequence on the
// LEDs each round, then collects the player's moves under a per-move timeout.
module exp7_sequenciador
   import exp7_pkg::*;
#(
   parameter int T_MOSTRA = T_MOSTRA_DEF,
   parameter int T_APAGA  = T_APAGA_DEF,
   parameter int T_LONGO  = T_LONGO_DEF,
   parameter int T_CURTO  = T_CURTO_DEF
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       iniciar,
   input  logic                       nivel_jogadas,
   input  logic                       nivel_tempo,
   exp7_sequenciador_if.master        dp,
   output logic                       acertou,
   output logic                       errou,
   output logic                       timeout,
   output logic                       pronto,
   output logic [3:0]                 db_estado,
   output logic [3:0]                 db_rodada
);

   estado_t              estado;
   estado_t              estado_next;
   logic [3:0]           rodada;
   logic [3:0]           endereco;
   logic [3:0]           ultima;
   logic                 nivel_jogadas_reg;
   logic                 nivel_tempo_reg;
   logic [TIMER_W-1:0]   limite;
   logic                 timer_zera;
   logic                 timer_conta;
   logic                 timer_fim;

   assign ultima    = nivel_jogadas_reg ? ULTIMA_LONGO : ULTIMA_CURTO;
   assign db_estado = estado;
   assign db_rodada = rodada;
   assign dp.endereco = endereco;

   // One timer serves all three timed phases; it restarts on every state change.
   always_comb begin
      limite      = TIMER_W'(T_MOSTRA);
      timer_conta = 1'b0;
      case (estado)
         ST_MOSTRA: begin
            limite      = TIMER_W'(T_MOSTRA);
            timer_conta = 1'b1;
         end
         ST_APAGA: begin
            limite      = TIMER_W'(T_APAGA);
            timer_conta = 1'b1;
         end
         ST_ESPERA: begin
            limite      = nivel_tempo_reg ? TIMER_W'(T_CURTO) : TIMER_W'(T_LONGO);
            timer_conta = 1'b1;
         end
         default: ;
      endcase
   end

   assign timer_zera = (estado_next != estado);

   contador_m #(
      .WIDTH (TIMER_W)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .zera   (timer_zera),
      .conta  (timer_conta),
      .limite (limite),
      .fim    (timer_fim)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         estado            <= ST_INICIAL;
         rodada            <= '0;
         endereco          <= '0;
         nivel_jogadas_reg <= 1'b0;
         nivel_tempo_reg   <= 1'b0;
      end else begin
         estado <= estado_next;
         case (estado)
            ST_PREPARACAO: begin
               rodada            <= '0;
               endereco          <= '0;
               nivel_jogadas_reg <= nivel_jogadas;
               nivel_tempo_reg   <= nivel_tempo;
            end
            ST_APAGA: begin
               if (timer_fim) begin
                  endereco <= (endereco == rodada) ? 4'd0 : endereco + 4'd1;
               end
            end
            ST_PROXIMA_JOGADA: endereco <= endereco + 4'd1;
            ST_PROXIMA_RODADA: begin
               rodada   <= rodada + 4'd1;
               endereco <= '0;
            end
            default: ;
         endcase
      end
   end

   // Next-state logic plus Moore decode of every output from the state register.
   always_comb begin
      estado_next    = estado;
      dp.mostra_leds = 1'b0;
      dp.zeraR       = 1'b0;
      dp.registraR   = 1'b0;
      acertou        = 1'b0;
      errou          = 1'b0;
      timeout        = 1'b0;
      pronto         = 1'b0;
      case (estado)
         ST_INICIAL: begin
            if (iniciar) estado_next = ST_PREPARACAO;
         end
         ST_PREPARACAO: begin
            dp.zeraR    = 1'b1;
            estado_next = ST_MOSTRA;
         end
         ST_MOSTRA: begin
            dp.mostra_leds = 1'b1;
            if (timer_fim) estado_next = ST_APAGA;
         end
         ST_APAGA: begin
            if (timer_fim) begin
               estado_next = (endereco == rodada) ? ST_ESPERA : ST_MOSTRA;
            end
         end
         ST_ESPERA: begin
            if (dp.jogada_feita) estado_next = ST_REGISTRA;
            else if (timer_fim)  estado_next = ST_FIM_TIMEOUT;
         end
         ST_REGISTRA: begin
            dp.registraR = 1'b1;
            estado_next  = ST_COMPARA;
         end
         ST_COMPARA: begin
            if (!dp.jogada_correta)     estado_next = ST_FIM_ERROU;
            else if (endereco != rodada) estado_next = ST_PROXIMA_JOGADA;
            else if (rodada == ultima)   estado_next = ST_FIM_ACERTOU;
            else                         estado_next = ST_PROXIMA_RODADA;
         end
         ST_PROXIMA_JOGADA: estado_next = ST_ESPERA;
         ST_PROXIMA_RODADA: estado_next = ST_MOSTRA;
         ST_FIM_ACERTOU: begin
            acertou = 1'b1;
            pronto  = 1'b1;
            if (iniciar) estado_next = ST_PREPARACAO;
         end
         ST_FIM_ERROU: begin
            errou  = 1'b1;
            pronto = 1'b1;
            if (iniciar) estado_next = ST_PREPARACAO;
         end
         ST_FIM_TIMEOUT: begin
            timeout = 1'b1;
            pronto  = 1'b1;
            if (iniciar) estado_next = ST_PREPARACAO;
         end
         default: estado_next = ST_INICIAL;
      endcase
   end

endmodule

// File: tb/tb_exp7_sequenciador.sv
// Scoreboard bench for the round sequencer: stimulus queues the expected
// state visits, a monitor compares every state change it observes.
module tb_exp7_sequenciador;
   import exp7_pkg::*;

   localparam int TM = 4;
   localparam int TA = 2;
   localparam int TL = 20;
   localparam int TC = 10;

   typedef struct {
      int estado;
      int endereco;
      int rodada;
      int dur;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic       nivel_jogadas;
   logic       nivel_tempo;
   logic       acertou;
   logic       errou;
   logic       timeout;
   logic       pronto;
   logic [3:0] db_estado;
   logic [3:0] db_rodada;

   exp7_sequenciador_if dp();

   exp7_sequenciador #(
      .T_MOSTRA (TM),
      .T_APAGA  (TA),
      .T_LONGO  (TL),
      .T_CURTO  (TC)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .iniciar       (iniciar),
      .nivel_jogadas (nivel_jogadas),
      .nivel_tempo   (nivel_tempo),
      .dp            (dp),
      .acertou       (acertou),
      .errou         (errou),
      .timeout       (timeout),
      .pronto        (pronto),
      .db_estado     (db_estado),
      .db_rodada     (db_rodada)
   );

   always #5 clock = ~clock;

   exp_t sb[$];
   int   total    = 0;
   int   failures = 0;

   // Expected {mostra_leds, zeraR, registraR, acertou, errou, timeout, pronto} per state.
   function automatic logic [6:0] flags_for(input int st);
      case (st)
         1:       return 7'b0100000;
         2:       return 7'b1000000;
         5:       return 7'b0010000;
         'hA:     return 7'b0001001;
         'hE:     return 7'b0000101;
         'hD:     return 7'b0000011;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic push(input int st, input int en, input int rod, input int dur);
      exp_t e;
      e.estado   = st;
      e.endereco = en;
      e.rodada   = rod;
      e.dur      = dur;
      sb.push_back(e);
   endtask

   task automatic push_show(input int r, input int first_dur);
      for (int e = 0; e <= r; e++) begin
         push(2, e, r, (e == 0) ? first_dur : TA);
         push(3, e, r, TM);
      end
      push(4, 0, r, TA);
   endtask

   task automatic checkOutput(input int st, input int en, input int rod, input int dur,
                              input logic [6:0] fl);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL transition: got state %0h end %0d rod %0d, expected none queued",
                  st, en, rod);
      end else begin
         e = sb.pop_front();
         if (st != e.estado || (e.endereco >= 0 && en != e.endereco) ||
             (e.rodada >= 0 && rod != e.rodada) || (e.dur >= 0 && dur != e.dur) ||
             fl != flags_for(e.estado)) begin
            failures++;
            $display("[TB] FAIL transition: got st=%0h end=%0d rod=%0d prevdur=%0d flags=%b, expected st=%0h end=%0d rod=%0d prevdur=%0d flags=%b",
                     st, en, rod, dur, fl, e.estado, e.endereco, e.rodada, e.dur,
                     flags_for(e.estado));
         end
      end
   endtask

   // Monitor: one comparison per observed state change, with time spent in the previous state.
   initial begin : monitor
      logic [3:0] prev_estado;
      int         in_state;
      prev_estado = 4'hF;
      in_state    = 0;
      forever begin
         @(negedge clock);
         if (db_estado !== prev_estado) begin
            checkOutput(int'(db_estado), int'(dp.endereco), int'(db_rodada), in_state,
                        {dp.mostra_leds, dp.zeraR, dp.registraR, acertou, errou, timeout, pronto});
            prev_estado = db_estado;
            in_state    = 1;
         end else begin
            in_state++;
         end
      end
   end

   task automatic wait_estado(input logic [3:0] code);
      int n;
      n = 0;
      while (db_estado !== code && n < 500) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (db_estado !== code) begin
         failures++;
         $display("[TB] FAIL wait_estado: got %h, expected %h within 500 cycles", db_estado, code);
      end
   endtask

   task automatic start_game(input logic nj, input logic nt);
      nivel_jogadas = nj;
      nivel_tempo   = nt;
      iniciar       = 1'b1;
      push(1, -1, -1, -1);
      push_show(0, 1);
      @(negedge clock);
      @(negedge clock);
      iniciar = 1'b0;
   endtask

   // Plays one move d cycles into espera and queues everything that follows it.
   task automatic applyStimulus(input int d, input bit correct, input int e, input int r,
                                input int ult);
      wait_estado(4'h4);
      repeat (d) @(negedge clock);
      push(5, e, r, d + 1);
      push(6, e, r, 1);
      if (!correct) begin
         push('hE, e, r, 1);
      end else if (e != r) begin
         push(7, e, r, 1);
         push(4, e + 1, r, 1);
      end else if (r == ult) begin
         push('hA, e, r, 1);
      end else begin
         push(8, e, r, 1);
         push_show(r + 1, 1);
      end
      dp.jogada_correta = correct;
      dp.jogada_feita   = 1'b1;
      @(negedge clock);
      dp.jogada_feita   = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      reset             = 1'b1;
      iniciar           = 1'b0;
      nivel_jogadas     = 1'b0;
      nivel_tempo       = 1'b0;
      dp.jogada_feita   = 1'b0;
      dp.jogada_correta = 1'b0;
      push(0, 0, 0, -1);
      @(negedge clock);
      reset = 1'b0;

      $display("[TB] full 8-round game, levels toggled mid-game");
      start_game(1'b0, 1'b0);
      for (int r = 0; r < 8; r++) begin
         if (r == 3) begin
            nivel_jogadas = 1'b1;
            nivel_tempo   = 1'b1;
         end
         for (int e = 0; e <= r; e++) begin
            applyStimulus((r == 4 && e == 0) ? 12 : (e + r) % 3, 1'b1, e, r, 7);
         end
      end
      wait_estado(4'hA);

      $display("[TB] wrong first move in round 2");
      start_game(1'b0, 1'b0);
      for (int r = 0; r < 2; r++) begin
         for (int e = 0; e <= r; e++) applyStimulus(1, 1'b1, e, r, 7);
      end
      applyStimulus(0, 1'b0, 0, 2, 7);
      wait_estado(4'hE);

      $display("[TB] timeout with short and long limits");
      start_game(1'b0, 1'b1);
      wait_estado(4'h4);
      push('hD, 0, 0, TC);
      wait_estado(4'hD);
      start_game(1'b0, 1'b0);
      wait_estado(4'h4);
      push('hD, 0, 0, TL);
      wait_estado(4'hD);

      $display("[TB] move on last timeout cycle, then reset during round 3");
      start_game(1'b0, 1'b1);
      applyStimulus(TC - 1, 1'b1, 0, 0, 7);
      for (int r = 1; r < 3; r++) begin
         for (int e = 0; e <= r; e++) applyStimulus(0, 1'b1, e, r, 7);
      end
      wait_estado(4'h2);
      @(negedge clock);
      sb.delete();
      push(0, 0, 0, -1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      total++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", total, failures);
      $finish;
   end

endmodule
